uart_helper_mc: RTL
===================

Name: uart_helper_mc

Overview:
Multi-channel, buffered successor to the single-channel simulation UART helper.
- Each channel has a TX FIFO, drained to the host through DPI-C by a round-robin drainer, and an RX FIFO, filled by periodic DPI-C host polling.
- Sits between SoC UART models and the simulation host in VCS/Verilator benches.
- Adds back-pressure, real input (getchar), and per-channel overflow flags.

Parameters:
NUM_CH, 2, number of independent UART channels (1..8)
TX_DEPTH, 16, TX FIFO entries per channel (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries per channel (power of 2, >=2)
POLL_INTERVAL, 1024, cycles between host RX polls of one channel (>=1)

Ports:
clock  input  1  sole clock; all logic on posedge
reset  input  1  synchronous, active-high reset
putchar_valid  input  NUM_CH  per-channel write strobe
putchar_ch  input  8*NUM_CH  char for channel i in bits [8i+7:8i]
putchar_ready  output  NUM_CH  TX FIFO i not full
getchar_valid  input  NUM_CH  pop request for RX FIFO i
getchar_ch  output  8*NUM_CH  RX FIFO i head; 0 when empty
getchar_ch_valid  output  NUM_CH  RX FIFO i non-empty
tx_overflow  output  NUM_CH  sticky: write attempted while TX FIFO i full

Behaviour:
- Interface is fixed: one clock, `clock`; synchronous active-high `reset`, sampled only on posedge `clock`.
- DPI imports:
  - `uart_putchar_ch(input byte ch, input byte c)`.
  - `uart_getchar_ch(input byte ch)` returns int; -1 means no char available, 0..255 is a char.
- Reset:
  - All FIFOs empty; pointers and counters 0; round-robin pointer 0; poll counter 0; tx_overflow 0.
  - Outputs after reset: putchar_ready all 1, getchar_ch_valid all 0, getchar_ch all 0.
  - While reset is high, no DPI call is made.
  - Reset mid-operation discards all buffered chars; nothing is flushed.
- TX write: putchar_valid[i] && putchar_ready[i] at posedge pushes the char. Visible to the drainer from the next cycle (1-cycle minimum latency to the DPI call).
- TX overflow: putchar_valid[i] && !putchar_ready[i] drops the char and sets tx_overflow[i]. The flag clears only on reset.
- TX drain:
  - At most one uart_putchar_ch call per cycle across all channels.
  - Arbiter picks the first non-empty channel at or after rr_ptr, cyclically, and pops one entry.
  - rr_ptr then becomes (granted+1) mod NUM_CH. If no channel is non-empty, rr_ptr holds.
- TX push and pop on the same channel in the same cycle: both occur and occupancy is unchanged. On a full FIFO, putchar_ready is low, so no push occurs that cycle.
- putchar_ready[i] = (count_tx[i] != TX_DEPTH). It is registered-count based, not a pop-aware bypass.
- RX poll scheduler:
  - Free-running poll counter counts 0..POLL_INTERVAL-1 and wraps.
  - On wrap, channel poll_ch is polled only if RX FIFO[poll_ch] is not full. A full FIFO is skipped with no DPI call.
  - poll_ch increments mod NUM_CH on every wrap, whether polled or skipped.
  - Return >=0: push low 8 bits; visible on getchar_ch_valid next cycle. Return -1: no push.
- RX pop: getchar_valid[i] && getchar_ch_valid[i] pops; next head appears next cycle. getchar_valid on an empty FIFO is ignored.
- RX push and pop on the same channel in the same cycle are both honoured.
- getchar_ch[i] is combinational from the head entry, forced to 0 when empty.
- FIFO pointers wrap mod depth; count widths are $clog2(depth)+1.
- No DPI function has side effects beyond the char transfer.

Test Plan:
- Reset, then write 'A','B','C' on ch0 on consecutive cycles -> host receives (0,'A'),(0,'B'),(0,'C') in order, the first call one cycle after the first write; putchar_ready[0] stays 1.
- NUM_CH=2: hold back-to-back writes on both channels for 4 cycles -> DPI calls alternate ch0,ch1,ch0,... one per cycle; no loss; tx_overflow stays 0.
- Block draining (host stub stalls via bench force), write TX_DEPTH+1=17 chars to ch1 -> putchar_ready[1]=0 after the 16th, the 17th is dropped, tx_overflow[1]=1; after drain, exactly 16 chars are received; the flag stays 1 until reset.
- POLL_INTERVAL=4, host stub returns 0x41 for ch0, -1 for ch1 -> ch0 is polled at cycles 3, 11, ... and getchar_ch_valid[0]=1 with getchar_ch=0x41 one cycle after each successful poll; ch1 stays invalid; pop via getchar_valid[0] clears it.
- Host always returns 0x5A; never pop ch0 -> RX FIFO fills to RX_DEPTH=8; subsequent ch0 poll slots make no DPI call; poll_ch still advances.
- Assert reset mid-stream with 5 chars buffered in TX and 3 in RX -> next cycle all getchar_ch_valid=0, getchar_ch=0, putchar_ready=1, tx_overflow=0; no DPI put calls occur for the discarded chars.

Source files
------------

// File: rtl/uart_helper_mc.sv
// Multi-channel buffered UART helper: per-channel TX/RX FIFOs, a round-robin TX drainer and a
// periodic RX poller that exchange characters with the simulation host.
package uart_helper_mc_host_pkg;
    // Host side of the character boundary, with the DPI-C signatures; the host queues live here.
    typedef struct packed {
        byte ch;
        byte c;
    } put_rec_t;

    put_rec_t put_log[$];
    int       get_log[$];
    int       get_rsp[8];

    function automatic void uart_putchar_ch(input byte ch, input byte c);
        put_log.push_back('{ch: ch, c: c});
    endfunction

    function automatic int uart_getchar_ch(input byte ch);
        get_log.push_back(int'(ch));
        return get_rsp[ch[2:0]];
    endfunction
endpackage

module uart_helper_mc
    import uart_helper_mc_host_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int TX_DEPTH      = 16,
    parameter int RX_DEPTH      = 8,
    parameter int POLL_INTERVAL = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   putchar_valid,
    input  logic [8*NUM_CH-1:0] putchar_ch,
    output logic [NUM_CH-1:0]   putchar_ready,
    input  logic [NUM_CH-1:0]   getchar_valid,
    output logic [8*NUM_CH-1:0] getchar_ch,
    output logic [NUM_CH-1:0]   getchar_ch_valid,
    output logic [NUM_CH-1:0]   tx_overflow
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam int TXC = TXA + 1;
    localparam int RXC = RXA + 1;
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

    logic [7:0]     tx_mem [NUM_CH][TX_DEPTH];
    logic [TXA-1:0] tx_wr  [NUM_CH];
    logic [TXA-1:0] tx_rd  [NUM_CH];
    logic [TXC-1:0] tx_cnt [NUM_CH];
    logic [7:0]     rx_mem [NUM_CH][RX_DEPTH];
    logic [RXA-1:0] rx_wr  [NUM_CH];
    logic [RXA-1:0] rx_rd  [NUM_CH];
    logic [RXC-1:0] rx_cnt [NUM_CH];

    logic [CHW-1:0]    rr_ptr, grant, poll_ch;
    logic [PW-1:0]     poll_cnt;
    logic              grant_valid, drain_go, poll_wrap, poll_go;
    logic [NUM_CH-1:0] tx_push, tx_pop, rx_pop;

    // First non-empty channel at or after rr_ptr, cyclically.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant       = rr_ptr;
        for (int off = 0; off < NUM_CH; off++) begin
            int idx;
            idx = (int'(rr_ptr) + off) % NUM_CH;
            if (!grant_valid && tx_cnt[idx] != '0) begin
                grant_valid = 1'b1;
                grant       = CHW'(idx);
            end
        end
    end

    assign drain_go  = grant_valid;
    assign poll_wrap = (poll_cnt == PW'(POLL_INTERVAL - 1));
    assign poll_go   = poll_wrap && (rx_cnt[poll_ch] != RXC'(RX_DEPTH));

    always_comb begin
        putchar_ready    = '0;
        getchar_ch_valid = '0;
        getchar_ch       = '0;
        tx_pop           = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            putchar_ready[i]    = (tx_cnt[i] != TXC'(TX_DEPTH));
            getchar_ch_valid[i] = (rx_cnt[i] != '0);
            tx_pop[i]           = drain_go && (grant == CHW'(i));
            if (rx_cnt[i] != '0) getchar_ch[8*i +: 8] = rx_mem[i][rx_rd[i]];
        end
    end

    assign tx_push = putchar_valid & putchar_ready;
    assign rx_pop  = getchar_valid & getchar_ch_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr   <= '0;
            poll_cnt <= '0;
            poll_ch  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (drain_go) rr_ptr <= (grant == CHW'(NUM_CH - 1)) ? '0 : grant + CHW'(1);
            poll_cnt <= poll_wrap ? '0 : poll_cnt + PW'(1);
            if (poll_wrap) poll_ch <= (poll_ch == CHW'(NUM_CH - 1)) ? '0 : poll_ch + CHW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: only pointers, counts and flags are reset; FIFO storage is don't-care while empty.
            for (int i = 0; i < NUM_CH; i++) begin
                tx_wr[i]       <= '0;
                tx_rd[i]       <= '0;
                tx_cnt[i]      <= '0;
                tx_overflow[i] <= 1'b0;
            end
        end else begin
            if (drain_go) uart_putchar_ch(byte'(grant), byte'(tx_mem[grant][tx_rd[grant]]));
            for (int i = 0; i < NUM_CH; i++) begin
                if (tx_push[i]) begin
                    tx_mem[i][tx_wr[i]] <= putchar_ch[8*i +: 8];
                    tx_wr[i]            <= tx_wr[i] + TXA'(1);
                end
                if (tx_pop[i]) tx_rd[i] <= tx_rd[i] + TXA'(1);
                if (putchar_valid[i] && !putchar_ready[i]) tx_overflow[i] <= 1'b1;
                tx_cnt[i] <= tx_cnt[i] + TXC'(tx_push[i]) - TXC'(tx_pop[i]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rx_wr[i]  <= '0;
                rx_rd[i]  <= '0;
                rx_cnt[i] <= '0;
            end
        end else begin : rx_update
            // The host answer is a process-local temporary consumed within this same edge.
            automatic int poll_ret;
            poll_ret = -1;
            if (poll_go) poll_ret = uart_getchar_ch(byte'(poll_ch));
            for (int i = 0; i < NUM_CH; i++) begin
                if (poll_ret >= 0 && poll_ch == CHW'(i)) begin
                    rx_mem[i][rx_wr[i]] <= poll_ret[7:0];
                    rx_wr[i]            <= rx_wr[i] + RXA'(1);
                end
                if (rx_pop[i]) rx_rd[i] <= rx_rd[i] + RXA'(1);
                rx_cnt[i] <= rx_cnt[i] + RXC'(poll_ret >= 0 && poll_ch == CHW'(i)) - RXC'(rx_pop[i]);
            end
        end
    end
endmodule
